uart_rx_deser: RTL and testbench

UART_RX_DESER -- requirements
Module: uart_rx_deser

---
 rtl/uart_rx_deser.sv | 164 ++++++++++++++++
 tb/tb_uart_rx_deser.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_deser.sv
// UART receiver that packs N_WORDS serial words into one wide output beat.
// Output register follows a valid/ready handshake; backpressure drops packets.
module uart_rx_deser #(
    parameter int CLOCKS_PER_PULSE = 434,
    parameter int BITS_PER_WORD    = 8,
    parameter int W_OUT            = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rx,
    output logic [W_OUT-1:0] m_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic             frame_err,
    output logic             overflow
);

    localparam int NW = W_OUT / BITS_PER_WORD;
    localparam int TW = $clog2(CLOCKS_PER_PULSE) + 1;
    localparam int CW = (NW > 1) ? $clog2(NW) : 1;
    localparam int BW = (BITS_PER_WORD > 1) ? $clog2(BITS_PER_WORD) : 1;

    localparam logic [TW-1:0] T_HALF = TW'(CLOCKS_PER_PULSE / 2 - 1);
    localparam logic [TW-1:0] T_FULL = TW'(CLOCKS_PER_PULSE - 1);
    localparam logic [BW-1:0] B_LAST = BW'(BITS_PER_WORD - 1);
    localparam logic [CW-1:0] W_LAST = CW'(NW - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t                   state_q, state_d;
    logic [1:0]               sync_q;
    logic [TW-1:0]            timer_q, timer_d;
    logic [BW-1:0]            bit_q, bit_d;
    logic [BITS_PER_WORD-1:0] shift_q, shift_d;
    logic [CW-1:0]            wcnt_q, wcnt_d;
    logic [W_OUT-1:0]         asm_q, asm_d;
    logic [W_OUT-1:0]         data_q, data_d;
    logic                     valid_q, valid_d;
    logic                     ferr_q, ferr_d;
    logic                     ovf_q, ovf_d;

    logic rx_s;
    logic half_tick;
    logic full_tick;
    logic load_req;

    assign rx_s      = sync_q[1];
    assign half_tick = (timer_q == T_HALF);
    assign full_tick = (timer_q == T_FULL);

    assign m_data    = data_q;
    assign m_valid   = valid_q;
    assign frame_err = ferr_q;
    assign overflow  = ovf_q;

    // Two-flop synchroniser; resets to the idle-high line level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) sync_q <= 2'b11;
        else     sync_q <= {sync_q[0], rx};
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // FSM next state: mid-bit start check, then fixed-period sampling.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (!rx_s) state_d = START;
            START: if (half_tick) state_d = rx_s ? IDLE : DATA;
            DATA:  if (full_tick && bit_q == B_LAST) state_d = STOP;
            STOP:  if (full_tick) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: bit timer, shifting, word assembly and output handshake.
    always_comb begin
        timer_d  = timer_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        wcnt_d   = wcnt_q;
        asm_d    = asm_q;
        data_d   = data_q;
        valid_d  = valid_q;
        ferr_d   = 1'b0;
        ovf_d    = ovf_q;
        load_req = 1'b0;
        unique case (state_q)
            IDLE: timer_d = '0;
            START: begin
                timer_d = half_tick ? '0 : timer_q + TW'(1);
                bit_d   = '0;
            end
            DATA: begin
                timer_d = full_tick ? '0 : timer_q + TW'(1);
                if (full_tick) begin
                    shift_d[bit_q] = rx_s;
                    bit_d          = bit_q + BW'(1);
                end
            end
            STOP: begin
                timer_d = full_tick ? '0 : timer_q + TW'(1);
                if (full_tick) begin
                    if (!rx_s) begin
                        ferr_d = 1'b1;
                    end else begin
                        for (int i = 0; i < NW; i++) begin
                            if (wcnt_q == CW'(i))
                                asm_d[i*BITS_PER_WORD +: BITS_PER_WORD] = shift_q;
                        end
                        if (wcnt_q == W_LAST) begin
                            wcnt_d   = '0;
                            load_req = 1'b1;
                        end else begin
                            wcnt_d = wcnt_q + CW'(1);
                        end
                    end
                end
            end
            default: timer_d = '0;
        endcase
        // A completed packet either lands in the output register or is lost.
        if (load_req) begin
            if (!valid_q || m_ready) begin
                data_d  = asm_d;
                valid_d = 1'b1;
            end else begin
                ovf_d = 1'b1;
            end
        end else if (valid_q && m_ready) begin
            valid_d = 1'b0;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer_q <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            wcnt_q  <= '0;
            asm_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            timer_q <= timer_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            wcnt_q  <= wcnt_d;
            asm_q   <= asm_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule

// File: tb/tb_uart_rx_deser.sv
// Self-checking bench for uart_rx_deser with a packet-level reference model.
// Uses a short bit period so every scenario fits in a small cycle budget.
module tb_uart_rx_deser;

    localparam int CPP = 40;
    localparam int BPW = 8;
    localparam int WO  = 24;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          rx = 1'b1;
    logic          m_ready = 1'b0;
    logic [WO-1:0] m_data;
    logic          m_valid;
    logic          frame_err;
    logic          overflow;

    int checks = 0;
    int errors = 0;

    logic [WO-1:0] got_q[$];
    logic [WO-1:0] exp_q[$];
    int vrun = 0;
    int max_run = 0;
    int ferr_cycles = 0;

    uart_rx_deser #(
        .CLOCKS_PER_PULSE(CPP),
        .BITS_PER_WORD(BPW),
        .W_OUT(WO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .rx(rx),
        .m_data(m_data),
        .m_valid(m_valid),
        .m_ready(m_ready),
        .frame_err(frame_err),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    // Observe handshakes, valid run lengths and error pulses.
    always @(negedge clk) begin
        if (!rst) begin
            if (m_valid && m_ready) got_q.push_back(m_data);
            if (m_valid) vrun++;
            else vrun = 0;
            if (vrun > max_run) max_run = vrun;
            if (frame_err) ferr_cycles++;
        end
    end

    function automatic logic [WO-1:0] pack3(input logic [7:0] b0,
                                            input logic [7:0] b1,
                                            input logic [7:0] b2);
        return WO'(b0) + (WO'(b1) << 8) + (WO'(b2) << 16);
    endfunction

    task automatic clear_obs();
        @(posedge clk);
        got_q.delete();
        max_run = 0;
        ferr_cycles = 0;
    endtask

    task automatic set_ready(input logic r);
        @(posedge clk);
        #1 m_ready = r;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        @(negedge clk);
        rx = 1'b0;
        repeat (CPP) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPP) @(negedge clk);
        end
        if (stop) begin
            rx = 1'b1;
            repeat (CPP) @(negedge clk);
        end else begin
            rx = 1'b0;
            repeat (3 * CPP / 4) @(negedge clk);
            rx = 1'b1;
            repeat (CPP / 4) @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (4) @(negedge clk);
        checks++;
        if (m_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_valid got %b want 0", m_valid);
        end
        checks++;
        if (m_data !== '0) begin
            errors++;
            $display("FAIL reset_data got %h want 0", m_data);
        end
        checks++;
        if (frame_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_ferr got %b want 0", frame_err);
        end
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_ovf got %b want 0", overflow);
        end
        rst = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_basic();
        logic [WO-1:0] e;
        set_ready(1'b1);
        clear_obs();
        send_frame(8'h21, 1'b1);
        send_frame(8'h43, 1'b1);
        send_frame(8'h65, 1'b1);
        repeat (4) @(negedge clk);
        e = pack3(8'h21, 8'h43, 8'h65);
        checks++;
        if (got_q.size() !== 1) begin
            errors++;
            $display("FAIL basic_count got %0d want 1", got_q.size());
        end else begin
            checks++;
            if (got_q[0] !== e) begin
                errors++;
                $display("FAIL basic_data got %h want %h", got_q[0], e);
            end
        end
        checks++;
        if (max_run !== 1) begin
            errors++;
            $display("FAIL basic_valid_len got %0d want 1", max_run);
        end
    endtask

    task automatic test_frame_err();
        logic [WO-1:0] e;
        clear_obs();
        send_frame(8'h5A, 1'b0);
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        send_frame(8'h33, 1'b1);
        repeat (4) @(negedge clk);
        e = pack3(8'h11, 8'h22, 8'h33);
        checks++;
        if (ferr_cycles !== 1) begin
            errors++;
            $display("FAIL ferr_pulses got %0d want 1", ferr_cycles);
        end
        checks++;
        if (got_q.size() !== 1 || got_q[0] !== e) begin
            errors++;
            $display("FAIL ferr_data got n=%0d %h want %h", got_q.size(),
                     got_q.size() > 0 ? got_q[0] : '0, e);
        end
    endtask

    task automatic test_false_start();
        logic [7:0] b[3];
        logic [WO-1:0] e;
        clear_obs();
        @(negedge clk);
        rx = 1'b0;
        repeat (CPP / 4) @(negedge clk);
        rx = 1'b1;
        repeat (2 * CPP) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            b[i] = 8'($urandom);
            send_frame(b[i], 1'b1);
        end
        repeat (4) @(negedge clk);
        e = pack3(b[0], b[1], b[2]);
        checks++;
        if (got_q.size() !== 1 || got_q[0] !== e) begin
            errors++;
            $display("FAIL glitch_data got n=%0d %h want %h", got_q.size(),
                     got_q.size() > 0 ? got_q[0] : '0, e);
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] b[3];
        logic [WO-1:0] e;
        set_ready(1'b0);
        clear_obs();
        for (int i = 0; i < 3; i++) begin
            b[i] = 8'($urandom);
            send_frame(b[i], 1'b1);
        end
        repeat (4) @(negedge clk);
        e = pack3(b[0], b[1], b[2]);
        checks++;
        if (m_valid !== 1'b1 || m_data !== e) begin
            errors++;
            $display("FAIL bp_first got v=%b %h want v=1 %h", m_valid, m_data, e);
        end
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("FAIL bp_ovf_early got %b want 0", overflow);
        end
        send_frame(8'hAA, 1'b1);
        send_frame(8'hBB, 1'b1);
        send_frame(8'hCC, 1'b1);
        repeat (4) @(negedge clk);
        checks++;
        if (m_valid !== 1'b1 || m_data !== e) begin
            errors++;
            $display("FAIL bp_hold got v=%b %h want v=1 %h", m_valid, m_data, e);
        end
        checks++;
        if (overflow !== 1'b1) begin
            errors++;
            $display("FAIL bp_ovf got %b want 1", overflow);
        end
        set_ready(1'b1);
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (m_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_drain got %b want 0", m_valid);
        end
        checks++;
        if (got_q.size() !== 1 || got_q[0] !== e) begin
            errors++;
            $display("FAIL bp_accept got n=%0d want 1 x %h", got_q.size(), e);
        end
        checks++;
        if (overflow !== 1'b1) begin
            errors++;
            $display("FAIL bp_sticky got %b want 1", overflow);
        end
    endtask

    task automatic test_reset_mid_packet();
        logic [WO-1:0] e;
        clear_obs();
        send_frame(8'($urandom), 1'b1);
        send_frame(8'($urandom), 1'b1);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (overflow !== 1'b0 || m_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_flags got ovf=%b v=%b want 0 0", overflow, m_valid);
        end
        rst = 1'b0;
        repeat (3) @(negedge clk);
        clear_obs();
        send_frame(8'h01, 1'b1);
        send_frame(8'h02, 1'b1);
        send_frame(8'h03, 1'b1);
        repeat (4) @(negedge clk);
        e = pack3(8'h01, 8'h02, 8'h03);
        checks++;
        if (got_q.size() !== 1 || got_q[0] !== e) begin
            errors++;
            $display("FAIL rst_mid_data got n=%0d %h want %h", got_q.size(),
                     got_q.size() > 0 ? got_q[0] : '0, e);
        end
    endtask

    task automatic test_random();
        logic [7:0] b[3];
        clear_obs();
        exp_q.delete();
        for (int p = 0; p < 10; p++) begin
            for (int i = 0; i < 3; i++) begin
                b[i] = 8'($urandom);
                send_frame(b[i], 1'b1);
                repeat ($urandom_range(1, 100)) @(negedge clk);
            end
            exp_q.push_back(pack3(b[0], b[1], b[2]));
        end
        repeat (4) @(negedge clk);
        checks++;
        if (got_q.size() !== exp_q.size()) begin
            errors++;
            $display("FAIL rand_count got %0d want %0d", got_q.size(), exp_q.size());
        end
        for (int p = 0; p < exp_q.size() && p < got_q.size(); p++) begin
            checks++;
            if (got_q[p] !== exp_q[p]) begin
                errors++;
                $display("FAIL rand_pkt%0d got %h want %h", p, got_q[p], exp_q[p]);
            end
        end
        checks++;
        if (ferr_cycles !== 0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL rand_flags got ferr=%0d ovf=%b want 0 0", ferr_cycles, overflow);
        end
        checks++;
        if (max_run !== 1) begin
            errors++;
            $display("FAIL rand_valid_len got %0d want 1", max_run);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_frame_err();
        test_false_start();
        test_backpressure();
        test_reset_mid_packet();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
